ldtu_synch_aligner: RTL and testbench
=====================================

LDTU_SYNCH_ALIGNER -- requirements
Module: ldtu_synch_aligner

Interface
REQ-001 Parameter Nbits_32, default 32, data word width.
REQ-002 Parameter LockCount, default 4, consecutive matching words required to lock.
REQ-003 Parameter UnlockCount, default 3, consecutive mismatching words required to lose lock.
REQ-004 Parameter HandshakeLen, default 4, handshake pulse length in CLK cycles.
REQ-005 CLK  input  1  single 160 MHz clock; all state updates on its rising edge.
REQ-006 rst_b  input  1  asynchronous, active-low reset.
REQ-007 synch  input  1  synch-mode request, the same level driven to the DTU output FIFO.
REQ-008 synch_pattern  input  Nbits_32  expected synch word, compared live every cycle and never latched.
REQ-009 DATA32_in  input  Nbits_32  word consumed from the DTU output stream (DATA32_DTU lane).
REQ-010 data_valid  input  1  DATA32_in is valid this cycle.
REQ-011 handshake  output  1  pulse returned to the DTU to end synch mode.
REQ-012 locked  output  1  alignment achieved.
REQ-013 align_error  output  1  one-cycle pulse on loss of lock.
REQ-014 err_cnt  output  8  saturating count of lock losses.

Function
REQ-015 The FSM SHALL have four states: IDLE, HUNT, LOCKED and HSHAKE.
REQ-016 Match is defined as data_valid=1 and DATA32_in==synch_pattern; mismatch is defined as data_valid=1 and DATA32_in!=synch_pattern.
REQ-017 Cycles with data_valid=0 SHALL leave the match and miss counters unchanged and SHALL cause no state transition other than those driven by synch.
REQ-018 IDLE: when synch=1 is sampled, the FSM SHALL move to HUNT on the next edge, and match_cnt and miss_cnt SHALL be cleared to 0.
REQ-019 HUNT: each match SHALL increment match_cnt and each mismatch SHALL clear it to 0.
REQ-020 HUNT: on the match that makes match_cnt equal LockCount, the FSM SHALL enter LOCKED, locked SHALL assert one cycle after that word is sampled, and match_cnt SHALL clear.
REQ-021 HUNT: synch=0 SHALL return the FSM to IDLE with no handshake, and SHALL take priority over a simultaneous LockCount-th match.
REQ-022 LOCKED: each mismatch SHALL increment miss_cnt and each match SHALL clear it.
REQ-023 LOCKED: when miss_cnt reaches UnlockCount, the FSM SHALL move to HUNT, locked SHALL deassert, align_error SHALL pulse for exactly one cycle, and err_cnt SHALL increment, saturating at 255 with no wrap.
REQ-024 LOCKED: synch=0 SHALL move the FSM to HSHAKE, and SHALL take priority over a simultaneous UnlockCount-th miss (no align_error pulse, err_cnt unchanged).
REQ-025 HSHAKE: handshake SHALL be high for exactly HandshakeLen consecutive cycles, starting the cycle after entry.
REQ-026 HSHAKE: locked SHALL stay high throughout, then the FSM SHALL return to IDLE with locked low.
REQ-027 HSHAKE: synch re-asserted during HSHAKE SHALL be ignored until the FSM reaches IDLE.
REQ-028 All outputs SHALL be registered; handshake, locked and align_error SHALL be glitch-free.
REQ-029 err_cnt SHALL be cleared only by reset.

Reset
REQ-030 While rst_b=0, asynchronously: FSM=IDLE, handshake=0, locked=0, align_error=0, err_cnt=0, and all internal counters 0.
REQ-031 Reset asserted mid-HSHAKE SHALL truncate the handshake pulse immediately.
REQ-032 After rst_b rises, the first transition SHALL be permitted on the second CLK edge.

Verification
REQ-033 Pattern 0x5A5A5A5A: synch=1, then 4 valid matching words -> locked=1 one cycle after the 4th word; handshake=0.
REQ-034 Sequence M,M,M,X,M,M,M,M (X = mismatch), with invalid cycles interleaved -> locked asserts only after the 8th word; invalid cycles do not disturb counting.
REQ-035 Locked, then 3 consecutive mismatches -> align_error is high for 1 cycle, locked=0, err_cnt=1; 2 mismatches then 1 match -> locked remains 1.
REQ-036 Locked, then synch drops -> handshake high for exactly 4 cycles, then IDLE with locked=0; synch pulsed during HSHAKE has no effect.
REQ-037 Force 256 lock losses -> err_cnt holds at 255.
REQ-038 rst_b pulsed low during the 2nd handshake cycle -> all outputs 0 immediately; err_cnt=0.

Source files
------------

// File: rtl/ldtu_synch_aligner.sv
// LDTU synch-word aligner.
// Hunts the DTU output stream for LockCount consecutive copies of the synch
// word, holds lock until UnlockCount consecutive misses, and returns a
// fixed-length handshake to the DTU when synch mode is released while locked.
`timescale 1ns/1ps
module ldtu_synch_aligner #(
  parameter int Nbits_32     = 32,
  parameter int LockCount    = 4,
  parameter int UnlockCount  = 3,
  parameter int HandshakeLen = 4
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                synch,
  input  logic [Nbits_32-1:0] synch_pattern,
  input  logic [Nbits_32-1:0] DATA32_in,
  input  logic                data_valid,
  output logic                handshake,
  output logic                locked,
  output logic                align_error,
  output logic [7:0]          err_cnt
);

  // Counters hold 0 .. N-1; reaching the last value plus one more event
  // triggers the transition, so they never need to represent N itself.
  localparam int MW = (LockCount    > 1) ? $clog2(LockCount)    : 1;
  localparam int UW = (UnlockCount  > 1) ? $clog2(UnlockCount)  : 1;
  localparam int HW = (HandshakeLen > 1) ? $clog2(HandshakeLen) : 1;

  localparam logic [MW-1:0] LOCK_LAST   = MW'(LockCount - 1);
  localparam logic [UW-1:0] UNLOCK_LAST = UW'(UnlockCount - 1);
  localparam logic [HW-1:0] HS_LAST     = HW'(HandshakeLen - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HUNT   = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [1:0] HSHAKE = 2'd3;

  logic [1:0]    state, state_nx;
  logic [MW-1:0] match_cnt, match_nx;
  logic [UW-1:0] miss_cnt, miss_nx;
  logic [HW-1:0] hs_cnt, hs_cnt_nx;
  logic          handshake_nx, locked_nx, align_error_nx;
  logic [7:0]    err_cnt_nx;
  logic          armed;
  logic          is_match, is_miss;

  // Lock-loss counter saturates at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign is_match = data_valid && (DATA32_in == synch_pattern);
  assign is_miss  = data_valid && (DATA32_in != synch_pattern);

  // The first edge after reset release only arms the FSM; transitions start on the second.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Next-state and next-output decode; synch always wins over data events.
  always_comb begin
    state_nx       = state;
    match_nx       = match_cnt;
    miss_nx        = miss_cnt;
    hs_cnt_nx      = hs_cnt;
    handshake_nx   = handshake;
    locked_nx      = locked;
    align_error_nx = 1'b0;
    err_cnt_nx     = err_cnt;
    if (armed) begin
      case (state)
        IDLE: begin
          if (synch) begin
            state_nx = HUNT;
            match_nx = '0;
            miss_nx  = '0;
          end
        end
        HUNT: begin
          if (!synch) begin
            state_nx = IDLE;
          end else if (is_match) begin
            if (match_cnt == LOCK_LAST) begin
              state_nx  = LOCKED;
              locked_nx = 1'b1;
              match_nx  = '0;
            end else begin
              match_nx = match_cnt + 1'b1;
            end
          end else if (is_miss) begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          if (!synch) begin
            state_nx     = HSHAKE;
            handshake_nx = 1'b1;
            hs_cnt_nx    = '0;
          end else if (is_miss) begin
            if (miss_cnt == UNLOCK_LAST) begin
              state_nx       = HUNT;
              locked_nx      = 1'b0;
              align_error_nx = 1'b1;
              err_cnt_nx     = sat_inc(err_cnt);
              miss_nx        = '0;
              match_nx       = '0;
            end else begin
              miss_nx = miss_cnt + 1'b1;
            end
          end else if (is_match) begin
            miss_nx = '0;
          end
        end
        HSHAKE: begin
          // synch and data are deliberately ignored until back in IDLE.
          if (hs_cnt == HS_LAST) begin
            state_nx     = IDLE;
            handshake_nx = 1'b0;
            locked_nx    = 1'b0;
            hs_cnt_nx    = '0;
          end else begin
            hs_cnt_nx = hs_cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State, counters and all outputs are registered so the DTU sees clean levels.
  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state       <= IDLE;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      hs_cnt      <= '0;
      handshake   <= 1'b0;
      locked      <= 1'b0;
      align_error <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      state       <= state_nx;
      match_cnt   <= match_nx;
      miss_cnt    <= miss_nx;
      hs_cnt      <= hs_cnt_nx;
      handshake   <= handshake_nx;
      locked      <= locked_nx;
      align_error <= align_error_nx;
      err_cnt     <= err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_ldtu_synch_aligner.sv
// Testbench for ldtu_synch_aligner: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_ldtu_synch_aligner;

  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 3;
  localparam int HS_N     = 4;

  logic        CLK;
  logic        rst_b;
  logic        synch;
  logic [31:0] synch_pattern;
  logic [31:0] DATA32_in;
  logic        data_valid;
  logic        handshake;
  logic        locked;
  logic        align_error;
  logic [7:0]  err_cnt;

  int n_vec;
  int n_fail;

  ldtu_synch_aligner #(
    .Nbits_32(32), .LockCount(LOCK_N), .UnlockCount(UNLOCK_N), .HandshakeLen(HS_N)
  ) dut (
    .CLK(CLK), .rst_b(rst_b), .synch(synch), .synch_pattern(synch_pattern),
    .DATA32_in(DATA32_in), .data_valid(data_valid), .handshake(handshake),
    .locked(locked), .align_error(align_error), .err_cnt(err_cnt)
  );

  initial CLK = 1'b0;
  always #3 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  // The aligner is described by what mode it is in and how long the current
  // run of good / bad words is; handshake is a countdown of remaining cycles.
  typedef enum int {M_OFF, M_SEARCH, M_ALIGNED, M_RELEASE} mode_t;
  mode_t mode;
  bit    ready;          // one idle edge after reset release
  int    good_run, bad_run, hs_left;
  bit    e_lk, e_hs, e_ae;
  int    e_ec;

  task automatic model_reset();
    mode = M_OFF; ready = 0; good_run = 0; bad_run = 0; hs_left = 0;
    e_lk = 0; e_hs = 0; e_ae = 0; e_ec = 0;
  endtask

  task automatic model_step(input bit s, input bit v, input bit m);
    e_ae = 0;
    if (!ready) begin
      ready = 1;
      return;
    end
    case (mode)
      M_OFF: if (s) begin mode = M_SEARCH; good_run = 0; bad_run = 0; end
      M_SEARCH: begin
        if (!s) mode = M_OFF;
        else if (v && m) begin
          good_run++;
          if (good_run == LOCK_N) begin mode = M_ALIGNED; e_lk = 1; good_run = 0; end
        end else if (v) good_run = 0;
      end
      M_ALIGNED: begin
        if (!s) begin mode = M_RELEASE; hs_left = HS_N; e_hs = 1; end
        else if (v && !m) begin
          bad_run++;
          if (bad_run == UNLOCK_N) begin
            mode = M_SEARCH; e_lk = 0; e_ae = 1; bad_run = 0; good_run = 0;
            e_ec = (e_ec < 255) ? e_ec + 1 : 255;
          end
        end else if (v) bad_run = 0;
      end
      M_RELEASE: begin
        hs_left--;
        if (hs_left == 0) begin mode = M_OFF; e_hs = 0; e_lk = 0; end
      end
      default: mode = M_OFF;
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".locked"},      int'(locked),      int'(e_lk));
    cmp({tag, ".handshake"},   int'(handshake),   int'(e_hs));
    cmp({tag, ".align_error"}, int'(align_error), int'(e_ae));
    cmp({tag, ".err_cnt"},     int'(err_cnt),     e_ec);
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample 1 ns later.
  task automatic cycle(input bit s, input bit v, input bit m, input string tag);
    synch      = s;
    data_valid = v;
    DATA32_in  = m ? synch_pattern : (synch_pattern ^ ($urandom() | 32'h1));
    @(posedge CLK);
    model_step(s, v, v && (DATA32_in == synch_pattern));
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_reset();
    #1;
    cmp("rst_async.locked",    int'(locked),      0);
    cmp("rst_async.handshake", int'(handshake),   0);
    cmp("rst_async.align_err", int'(align_error), 0);
    cmp("rst_async.err_cnt",   int'(err_cnt),     0);
    repeat (2) @(posedge CLK);
    #1;
    rst_b = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit s; bit v; bit m;
    bit lk; bit hs; bit ae; int ec;
  } vec_t;

  vec_t tbl[32];

  initial begin
    n_vec = 0; n_fail = 0;
    rst_b = 1'b0; synch = 1'b0; data_valid = 1'b0;
    DATA32_in = '0; synch_pattern = 32'h5A5A5A5A;
    model_reset();

    //         s  v  m   lk hs ae ec
    tbl[0]  = '{0, 0, 0,  0, 0, 0, 0};  // arming edge
    tbl[1]  = '{1, 0, 0,  0, 0, 0, 0};  // IDLE -> HUNT
    tbl[2]  = '{1, 1, 1,  0, 0, 0, 0};  // M1
    tbl[3]  = '{1, 0, 0,  0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1,  0, 0, 0, 0};  // M2
    tbl[5]  = '{1, 1, 1,  0, 0, 0, 0};  // M3
    tbl[6]  = '{1, 1, 0,  0, 0, 0, 0};  // X resets run
    tbl[7]  = '{1, 1, 1,  0, 0, 0, 0};  // M1
    tbl[8]  = '{1, 0, 0,  0, 0, 0, 0};
    tbl[9]  = '{1, 1, 1,  0, 0, 0, 0};  // M2
    tbl[10] = '{1, 1, 1,  0, 0, 0, 0};  // M3
    tbl[11] = '{1, 0, 0,  0, 0, 0, 0};
    tbl[12] = '{1, 1, 1,  1, 0, 0, 0};  // M4 -> locked (8th word)
    tbl[13] = '{1, 1, 0,  1, 0, 0, 0};  // miss 1
    tbl[14] = '{1, 1, 0,  1, 0, 0, 0};  // miss 2
    tbl[15] = '{1, 1, 1,  1, 0, 0, 0};  // match clears misses
    tbl[16] = '{1, 1, 0,  1, 0, 0, 0};  // miss 1
    tbl[17] = '{1, 0, 0,  1, 0, 0, 0};
    tbl[18] = '{1, 1, 0,  1, 0, 0, 0};  // miss 2
    tbl[19] = '{1, 1, 0,  0, 0, 1, 1};  // miss 3 -> lock loss
    tbl[20] = '{1, 0, 0,  0, 0, 0, 1};  // pulse lasts one cycle
    tbl[21] = '{1, 1, 1,  0, 0, 0, 1};
    tbl[22] = '{1, 1, 1,  0, 0, 0, 1};
    tbl[23] = '{1, 1, 1,  0, 0, 0, 1};
    tbl[24] = '{1, 1, 1,  1, 0, 0, 1};  // relocked
    tbl[25] = '{0, 0, 0,  1, 1, 0, 1};  // synch drop -> handshake 1
    tbl[26] = '{1, 0, 0,  1, 1, 0, 1};  // synch pulse ignored, hs 2
    tbl[27] = '{0, 0, 0,  1, 1, 0, 1};  // hs 3
    tbl[28] = '{1, 0, 0,  1, 1, 0, 1};  // hs 4
    tbl[29] = '{1, 0, 0,  0, 0, 0, 1};  // back to IDLE
    tbl[30] = '{0, 0, 0,  0, 0, 0, 1};
    tbl[31] = '{0, 1, 1,  0, 0, 0, 1};  // IDLE ignores data

    #1;
    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].m, $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d.lk", i), int'(locked),      int'(tbl[i].lk));
      cmp($sformatf("tbl%0d.hs", i), int'(handshake),   int'(tbl[i].hs));
      cmp($sformatf("tbl%0d.ae", i), int'(align_error), int'(tbl[i].ae));
      cmp($sformatf("tbl%0d.ec", i), int'(err_cnt),     tbl[i].ec);
    end

    // First edge after reset release must not act on synch.
    do_reset();
    cycle(1, 0, 0, "arm0");
    cycle(1, 1, 1, "arm1");
    repeat (3) cycle(1, 1, 1, "arm_m");
    cmp("arm.not_yet_locked", int'(locked), 0);
    cycle(1, 1, 1, "arm_m4");
    cmp("arm.locked", int'(locked), 1);

    // HUNT: synch drop beats a simultaneous LockCount-th match.
    do_reset();
    cycle(0, 0, 0, "hp_arm");
    cycle(1, 0, 0, "hp_go");
    repeat (3) cycle(1, 1, 1, "hp_m");
    cycle(0, 1, 1, "hp_drop");
    cmp("hunt_prio.locked", int'(locked), 0);
    cmp("hunt_prio.handshake", int'(handshake), 0);
    cycle(0, 0, 0, "hp_idle");

    // LOCKED: synch drop beats a simultaneous UnlockCount-th miss.
    cycle(1, 0, 0, "lp_go");
    repeat (4) cycle(1, 1, 1, "lp_m");
    repeat (2) cycle(1, 1, 0, "lp_x");
    cycle(0, 1, 0, "lp_drop");
    cmp("lock_prio.align_error", int'(align_error), 0);
    cmp("lock_prio.handshake", int'(handshake), 1);
    cmp("lock_prio.err_cnt", int'(err_cnt), 0);
    repeat (5) cycle(0, 0, 0, "lp_hs");
    cmp("lock_prio.idle_locked", int'(locked), 0);

    // Reset during the 2nd handshake cycle truncates everything at once.
    do_reset();
    cycle(0, 0, 0, "rh_arm");
    cycle(1, 0, 0, "rh_go");
    repeat (4) cycle(1, 1, 1, "rh_m");
    repeat (3) cycle(1, 1, 0, "rh_x");
    cmp("rst_hs.err_before", int'(err_cnt), 1);
    repeat (4) cycle(1, 1, 1, "rh_m2");
    cycle(0, 0, 0, "rh_hs1");
    cycle(0, 0, 0, "rh_hs2");
    cmp("rst_hs.hs_before", int'(handshake), 1);
    do_reset();

    // 256 lock losses saturate the error counter.
    cycle(0, 0, 0, "sat_arm");
    cycle(1, 0, 0, "sat_go");
    for (int k = 0; k < 256; k++) begin
      repeat (4) cycle(1, 1, 1, "sat_m");
      repeat (3) cycle(1, 1, 0, "sat_x");
      if (k == 0) cmp("sat.first", int'(err_cnt), 1);
    end
    cmp("sat.err_cnt", int'(err_cnt), 255);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0)
        synch_pattern = ($urandom_range(0, 1) == 0) ? 32'h5A5A5A5A : $urandom();
      cycle($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 80, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
